// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period and high time of a slow, asynchronous
// pulse train in system-clock counts, with lock and stall detection.
//
// Ports:
//   clk        system clock, all logic on its rising edge
//   rst        asynchronous, active-high reset
//   sig_in     measured signal, asynchronous to clk
//   period     clk cycles between the last two rising edges of sig_in
//   high_time  clk cycles sig_in was high within that period
//   meas_valid one-cycle pulse when period/high_time update
//   locked     two consecutive identical periods measured
//   timeout    sig_in stopped toggling (sticky until the next rise)
module clk_period_meter #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 32'h0000_FFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic             s, s_d;
  logic             rise, fall, stall;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] h_lat, h_lat_nxt;
  logic [CNT_W-1:0] period_nxt, high_time_nxt;
  logic             meas_valid_nxt, locked_nxt, timeout_nxt;

  // Synchroniser chain plus one delay flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_d    <= s;
    end
  end

  assign s     = sync_q[SYNC_STAGES-1];
  assign rise  = s & ~s_d;
  assign fall  = ~s & s_d;
  // Stall only when no edge lands in the same cycle: a rise exactly at the
  // limit still produces a measurement.
  assign stall = (cnt == TIMEOUT_C) & ~rise & ~fall;

  // Cycle counter restarts at 1 on each rise, saturating otherwise
  always_comb begin
    cnt_nxt = cnt;
    if (rise)                cnt_nxt = CNT_W'(1);
    else if (cnt != CNT_MAX) cnt_nxt = cnt + CNT_W'(1);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and next output values
  always_comb begin
    state_nxt      = state;
    h_lat_nxt      = h_lat;
    period_nxt     = period;
    high_time_nxt  = high_time;
    meas_valid_nxt = 1'b0;
    locked_nxt     = locked;
    timeout_nxt    = timeout;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_nxt   = HIGH;
          timeout_nxt = 1'b0;
        end
      end
      HIGH: begin
        if (rise) begin
          // Missed fall: whole period counts as high
          period_nxt     = cnt;
          high_time_nxt  = cnt;
          meas_valid_nxt = 1'b1;
          locked_nxt     = (cnt == period);
        end else if (fall) begin
          h_lat_nxt = cnt;
          state_nxt = LOW;
        end else if (stall) begin
          timeout_nxt = 1'b1;
          locked_nxt  = 1'b0;
          state_nxt   = IDLE;
        end
      end
      LOW: begin
        if (rise) begin
          period_nxt     = cnt;
          high_time_nxt  = h_lat;
          meas_valid_nxt = 1'b1;
          locked_nxt     = (cnt == period);
          state_nxt      = HIGH;
        end else if (stall) begin
          timeout_nxt = 1'b1;
          locked_nxt  = 1'b0;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      h_lat      <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      h_lat      <= h_lat_nxt;
      period     <= period_nxt;
      high_time  <= high_time_nxt;
      meas_valid <= meas_valid_nxt;
      locked     <= locked_nxt;
      timeout    <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: self-checking bench for clk_period_meter.
// A reference model tracks rise/fall times of the synchronised input and
// predicts measurements, lock and timeout from plain arithmetic on them.
module tb_clk_period_meter;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned SYNC  = 2;
  localparam int unsigned TMO   = 20;

  logic             clk;
  logic             rst;
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             locked;
  logic             timeout;

  clk_period_meter #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC),
    .TIMEOUT    (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sig_in    (sig_in),
    .period    (period),
    .high_time (high_time),
    .meas_valid(meas_valid),
    .locked    (locked),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  logic stim[$];

  // Reference model state
  logic             mq[$];     // synchroniser delay line, oldest first
  int               n;         // clk edges since reset release
  bit               armed;     // a rise has been seen since reset/timeout
  bit               fell;      // a fall has been seen since the last rise
  int               last_rise;
  int               fall_at;
  logic [CNT_W-1:0] exp_period;
  logic [CNT_W-1:0] exp_high;
  logic             exp_mv;
  logic             exp_locked;
  logic             exp_timeout;

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < int'(SYNC) + 1; i++) mq.push_back(1'b0);
    n = 0; armed = 0; fell = 0; last_rise = 0; fall_at = 0;
    exp_period = '0; exp_high = '0; exp_mv = 1'b0;
    exp_locked = 1'b0; exp_timeout = 1'b0;
  endtask

  task automatic model_edge(input logic v);
    logic s_m, sd_m;
    int   since;
    s_m  = mq[SYNC-1];
    sd_m = mq[SYNC-2];
    n++;
    since  = n - last_rise;
    exp_mv = 1'b0;
    if (s_m && !sd_m) begin
      if (armed) begin
        exp_locked = (CNT_W'(since) == exp_period);
        exp_period = CNT_W'(since);
        exp_high   = fell ? CNT_W'(fall_at - last_rise) : CNT_W'(since);
        exp_mv     = 1'b1;
      end
      exp_timeout = 1'b0;
      armed = 1; fell = 0; last_rise = n;
    end else if (!s_m && sd_m) begin
      if (armed && !fell) begin
        fell = 1; fall_at = n;
      end
    end else if (armed && since == int'(TMO)) begin
      exp_timeout = 1'b1;
      exp_locked  = 1'b0;
      armed       = 0;
    end
    mq.push_back(v);
    void'(mq.pop_front());
  endtask

  task automatic step(input logic v);
    @(negedge clk);
    sig_in = v;
    @(posedge clk);
    model_edge(v);
    #1;
  endtask

  task automatic add_wave(input int hi, input int lo, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < hi; i++) stim.push_back(1'b1);
      for (int i = 0; i < lo; i++) stim.push_back(1'b0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sig_in = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (period !== '0) begin bad++; $display("FAIL reset period got=%0d exp=0", period); end
    total++; if (high_time !== '0) begin bad++; $display("FAIL reset high_time got=%0d exp=0", high_time); end
    total++; if (meas_valid !== 1'b0) begin bad++; $display("FAIL reset meas_valid got=%b exp=0", meas_valid); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset locked got=%b exp=0", locked); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset timeout got=%b exp=0", timeout); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_div5();
    int nmv;
    nmv = 0;
    stim.delete();
    add_wave(3, 2, 6);
    foreach (stim[i]) begin
      step(stim[i]);
      total++; if (meas_valid !== exp_mv) begin bad++; $display("FAIL div5 meas_valid n=%0d got=%b exp=%b", n, meas_valid, exp_mv); end
      total++; if (locked !== exp_locked) begin bad++; $display("FAIL div5 locked n=%0d got=%b exp=%b", n, locked, exp_locked); end
      total++; if (timeout !== exp_timeout) begin bad++; $display("FAIL div5 timeout n=%0d got=%b exp=%b", n, timeout, exp_timeout); end
      total++; if ({period, high_time} !== {exp_period, exp_high}) begin bad++; $display("FAIL div5 meas n=%0d got=%0d/%0d exp=%0d/%0d", n, period, high_time, exp_period, exp_high); end
      if (meas_valid === 1'b1) begin
        nmv++;
        total++; if (period !== 16'd5 || high_time !== 16'd3) begin bad++; $display("FAIL div5 value got=%0d/%0d exp=5/3", period, high_time); end
        if (nmv >= 2) begin
          total++; if (locked !== 1'b1) begin bad++; $display("FAIL div5 lock got=%b exp=1", locked); end
        end
      end
    end
    total++; if (nmv != 5) begin bad++; $display("FAIL div5 pulse_count got=%0d exp=5", nmv); end
  endtask

  task automatic test_duty();
    logic [CNT_W-1:0] last_high;
    last_high = '0;
    stim.delete();
    add_wave(2, 3, 5);
    foreach (stim[i]) begin
      step(stim[i]);
      total++; if (meas_valid !== exp_mv) begin bad++; $display("FAIL duty meas_valid n=%0d got=%b exp=%b", n, meas_valid, exp_mv); end
      total++; if (locked !== exp_locked) begin bad++; $display("FAIL duty locked n=%0d got=%b exp=%b", n, locked, exp_locked); end
      total++; if (timeout !== exp_timeout) begin bad++; $display("FAIL duty timeout n=%0d got=%b exp=%b", n, timeout, exp_timeout); end
      total++; if ({period, high_time} !== {exp_period, exp_high}) begin bad++; $display("FAIL duty meas n=%0d got=%0d/%0d exp=%0d/%0d", n, period, high_time, exp_period, exp_high); end
      if (meas_valid === 1'b1) begin
        last_high = high_time;
        total++; if (period !== 16'd5 || locked !== 1'b1) begin bad++; $display("FAIL duty stable got=%0d lock=%b exp=5 lock=1", period, locked); end
      end
    end
    total++; if (last_high !== 16'd2) begin bad++; $display("FAIL duty high got=%0d exp=2", last_high); end
  endtask

  task automatic test_period_change();
    int k7;
    k7 = 0;
    stim.delete();
    add_wave(3, 4, 4);
    foreach (stim[i]) begin
      step(stim[i]);
      total++; if (meas_valid !== exp_mv) begin bad++; $display("FAIL pchg meas_valid n=%0d got=%b exp=%b", n, meas_valid, exp_mv); end
      total++; if (locked !== exp_locked) begin bad++; $display("FAIL pchg locked n=%0d got=%b exp=%b", n, locked, exp_locked); end
      total++; if (timeout !== exp_timeout) begin bad++; $display("FAIL pchg timeout n=%0d got=%b exp=%b", n, timeout, exp_timeout); end
      total++; if ({period, high_time} !== {exp_period, exp_high}) begin bad++; $display("FAIL pchg meas n=%0d got=%0d/%0d exp=%0d/%0d", n, period, high_time, exp_period, exp_high); end
      if (meas_valid === 1'b1 && period === 16'd7) begin
        k7++;
        total++; if (locked !== (k7 >= 2)) begin bad++; $display("FAIL pchg lock k=%0d got=%b exp=%b", k7, locked, k7 >= 2); end
      end
    end
    total++; if (k7 != 3) begin bad++; $display("FAIL pchg count got=%0d exp=3", k7); end
  endtask

  task automatic test_timeout();
    int first_to;
    int mv_after;
    first_to = -1;
    mv_after = 0;
    stim.delete();
    add_wave(0, 30, 1);
    add_wave(4, 0, 1);
    foreach (stim[i]) begin
      step(stim[i]);
      total++; if (meas_valid !== exp_mv) begin bad++; $display("FAIL tmo meas_valid n=%0d got=%b exp=%b", n, meas_valid, exp_mv); end
      total++; if (locked !== exp_locked) begin bad++; $display("FAIL tmo locked n=%0d got=%b exp=%b", n, locked, exp_locked); end
      total++; if (timeout !== exp_timeout) begin bad++; $display("FAIL tmo timeout n=%0d got=%b exp=%b", n, timeout, exp_timeout); end
      total++; if ({period, high_time} !== {exp_period, exp_high}) begin bad++; $display("FAIL tmo meas n=%0d got=%0d/%0d exp=%0d/%0d", n, period, high_time, exp_period, exp_high); end
      if (timeout === 1'b1 && first_to < 0) first_to = i;
      if (i >= 30 && meas_valid === 1'b1) mv_after++;
      if (i == 29) begin
        total++; if ({timeout, locked} !== 2'b10) begin bad++; $display("FAIL tmo flags got=%b%b exp=10", timeout, locked); end
        total++; if (period !== 16'd7 || high_time !== 16'd3) begin bad++; $display("FAIL tmo hold got=%0d/%0d exp=7/3", period, high_time); end
      end
    end
    // last rise event landed 5 steps before this test; 20 cycles later timeout shows
    total++; if (first_to != 15) begin bad++; $display("FAIL tmo when got=%0d exp=15", first_to); end
    total++; if (timeout !== 1'b0 || mv_after != 0) begin bad++; $display("FAIL tmo clear got=%b mv=%0d exp=0 mv=0", timeout, mv_after); end
  endtask

  task automatic test_min_period();
    stim.delete();
    for (int i = 0; i < 24; i++) stim.push_back(logic'(i % 2));
    foreach (stim[i]) begin
      step(stim[i]);
      total++; if (meas_valid !== exp_mv) begin bad++; $display("FAIL min meas_valid n=%0d got=%b exp=%b", n, meas_valid, exp_mv); end
      total++; if (locked !== exp_locked) begin bad++; $display("FAIL min locked n=%0d got=%b exp=%b", n, locked, exp_locked); end
      total++; if (timeout !== exp_timeout) begin bad++; $display("FAIL min timeout n=%0d got=%b exp=%b", n, timeout, exp_timeout); end
      total++; if ({period, high_time} !== {exp_period, exp_high}) begin bad++; $display("FAIL min meas n=%0d got=%0d/%0d exp=%0d/%0d", n, period, high_time, exp_period, exp_high); end
      if (i >= 6 && meas_valid === 1'b1) begin
        total++; if (period !== 16'd2 || high_time !== 16'd1) begin bad++; $display("FAIL min value got=%0d/%0d exp=2/1", period, high_time); end
      end
    end
  endtask

  task automatic test_boundary();
    int n20;
    bit saw_to;
    n20 = 0;
    saw_to = 0;
    stim.delete();
    add_wave(0, 3, 1);
    add_wave(5, 15, 3);
    add_wave(5, 16, 2);
    foreach (stim[i]) begin
      step(stim[i]);
      total++; if (meas_valid !== exp_mv) begin bad++; $display("FAIL bound meas_valid n=%0d got=%b exp=%b", n, meas_valid, exp_mv); end
      total++; if (locked !== exp_locked) begin bad++; $display("FAIL bound locked n=%0d got=%b exp=%b", n, locked, exp_locked); end
      total++; if (timeout !== exp_timeout) begin bad++; $display("FAIL bound timeout n=%0d got=%b exp=%b", n, timeout, exp_timeout); end
      total++; if ({period, high_time} !== {exp_period, exp_high}) begin bad++; $display("FAIL bound meas n=%0d got=%0d/%0d exp=%0d/%0d", n, period, high_time, exp_period, exp_high); end
      if (meas_valid === 1'b1 && period === 16'd20) n20++;
      if (timeout === 1'b1) saw_to = 1;
    end
    total++; if (n20 != 3 || !saw_to) begin bad++; $display("FAIL bound edge_at_limit got=%0d to=%b exp=3 to=1", n20, saw_to); end
  endtask

  task automatic test_reset_mid();
    int nmv;
    bit first_ok;
    nmv = 0;
    first_ok = 0;
    stim.delete();
    add_wave(3, 2, 3);
    foreach (stim[i]) step(stim[i]);
    #2;
    rst = 1'b1;
    #1;
    total++; if ({period, high_time} !== '0) begin bad++; $display("FAIL rstmid meas got=%0d/%0d exp=0/0", period, high_time); end
    total++; if ({meas_valid, locked, timeout} !== 3'b000) begin bad++; $display("FAIL rstmid flags got=%b%b%b exp=000", meas_valid, locked, timeout); end
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    stim.delete();
    add_wave(3, 2, 4);
    foreach (stim[i]) begin
      step(stim[i]);
      total++; if (meas_valid !== exp_mv) begin bad++; $display("FAIL rstmid meas_valid n=%0d got=%b exp=%b", n, meas_valid, exp_mv); end
      total++; if (locked !== exp_locked) begin bad++; $display("FAIL rstmid locked n=%0d got=%b exp=%b", n, locked, exp_locked); end
      total++; if (timeout !== exp_timeout) begin bad++; $display("FAIL rstmid timeout n=%0d got=%b exp=%b", n, timeout, exp_timeout); end
      total++; if ({period, high_time} !== {exp_period, exp_high}) begin bad++; $display("FAIL rstmid meas n=%0d got=%0d/%0d exp=%0d/%0d", n, period, high_time, exp_period, exp_high); end
      if (meas_valid === 1'b1) begin
        nmv++;
        if (nmv == 1) first_ok = (period === 16'd5) && (high_time === 16'd3) && (locked === 1'b0);
      end
    end
    total++; if (nmv != 3 || !first_ok) begin bad++; $display("FAIL rstmid after got=%0d first_ok=%b exp=3 first_ok=1", nmv, first_ok); end
  endtask

  task automatic test_random();
    stim.delete();
    for (int k = 0; k < 16; k++) begin
      add_wave(int'($urandom_range(1, 8)), int'($urandom_range(1, 24)), 1);
    end
    foreach (stim[i]) begin
      step(stim[i]);
      total++; if (meas_valid !== exp_mv) begin bad++; $display("FAIL rand meas_valid n=%0d got=%b exp=%b", n, meas_valid, exp_mv); end
      total++; if (locked !== exp_locked) begin bad++; $display("FAIL rand locked n=%0d got=%b exp=%b", n, locked, exp_locked); end
      total++; if (timeout !== exp_timeout) begin bad++; $display("FAIL rand timeout n=%0d got=%b exp=%b", n, timeout, exp_timeout); end
      total++; if ({period, high_time} !== {exp_period, exp_high}) begin bad++; $display("FAIL rand meas n=%0d got=%0d/%0d exp=%0d/%0d", n, period, high_time, exp_period, exp_high); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_div5();
    test_duty();
    test_period_change();
    test_timeout();
    test_min_period();
    test_boundary();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
